// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: round-robin sharing of one character LCD driver between two byte FIFOs (A, B).
// Optional LCD_ARB_STATS_EN adds per-port completed-character counters oA_Count/oB_Count.
module lcd_write_arbiter #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic        Clock,
  input  logic        Reset,
`ifdef LCD_ARB_STATS_EN
  output logic [15:0] oA_Count,
  output logic [15:0] oB_Count,
`endif
  input  logic        iA_Valid,
  input  logic [7:0]  iA_Data,
  output logic        oA_Ready,
  input  logic        iB_Valid,
  input  logic [7:0]  iB_Data,
  output logic        oB_Ready,
  input  logic        iLCD_Ready,
  input  logic        iLCD_IsInitialized,
  output logic        oLCD_Write,
  output logic [7:0]  oLCD_Data,
  output logic [1:0]  oGrant,
  output logic        oBusy,
  output logic        oRetry
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_WAIT_DONE} state_t;

  logic [1:0]      push, pop, full, empty;
  logic [1:0][7:0] in_data, head;

  assign in_data = {iB_Data, iA_Data};
  assign push    = {iB_Valid & ~full[1], iA_Valid & ~full[0]};
  assign oA_Ready = ~full[0];
  assign oB_Ready = ~full[1];

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push[g]) begin
        mem_d[wr_q] = in_data[g];
        wr_d = wr_q + 1'b1;
      end
      if (pop[g]) rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + (AW+1)'(push[g]) - (AW+1)'(pop[g]);
    end
    always_ff @(posedge Clock) begin
      if (Reset) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        wr_q  <= wr_d;
        rd_q  <= rd_d;
        cnt_q <= cnt_d;
      end
    end
    always_ff @(posedge Clock) mem_q <= mem_d;
    assign full[g]  = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign empty[g] = cnt_q == '0;
    assign head[g]  = mem_q[rd_q];
  end

  state_t        state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    grant_q, grant_d;
  logic          write_q, write_d, retry_q, retry_d;
  logic          last_b_q, last_b_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          sel_b, done;

  // B wins when A is empty, or when both wait and A was served last
  assign sel_b = empty[0] | (~empty[1] & ~last_b_q);
  assign done  = state_q == S_WAIT_DONE && iLCD_Ready;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    grant_d  = grant_q;
    write_d  = 1'b0;
    retry_d  = 1'b0;
    last_b_d = last_b_q;
    timer_d  = timer_q;
    pop      = 2'b00;
    case (state_q)
      S_IDLE: if (iLCD_Ready && iLCD_IsInitialized && !(&empty)) begin
        pop     = sel_b ? 2'b10 : 2'b01;
        data_d  = head[sel_b];
        grant_d = sel_b ? 2'b10 : 2'b01;
        write_d = 1'b1;
        timer_d = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: if (!iLCD_Ready) state_d = S_WAIT_DONE;
      else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
        write_d = 1'b1;
        retry_d = 1'b1;
        timer_d = '0;
      end else timer_d = timer_q + 1'b1;
      S_WAIT_DONE: if (done) begin
        grant_d  = 2'b00;
        last_b_d = grant_q[1];
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      grant_q  <= '0;
      write_q  <= 1'b0;
      retry_q  <= 1'b0;
      last_b_q <= 1'b1;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      write_q  <= write_d;
      retry_q  <= retry_d;
      last_b_q <= last_b_d;
      timer_q  <= timer_d;
    end
  end

  assign oLCD_Write = write_q;
  assign oLCD_Data  = data_q;
  assign oGrant     = grant_q;
  assign oBusy      = state_q != S_IDLE;
  assign oRetry     = retry_q;

`ifdef LCD_ARB_STATS_EN
  logic [15:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  always_comb begin
    a_cnt_d = a_cnt_q + 16'(done & grant_q[0]);
    b_cnt_d = b_cnt_q + 16'(done & grant_q[1]);
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end
  assign oA_Count = a_cnt_q;
  assign oB_Count = b_cnt_q;
`endif
endmodule
